// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern feeder.
package seq_pkg;

    // Serializer control states: waiting for a word, or streaming one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default parallel word width.
    localparam int DEFAULT_WIDTH = 8;

    // Width of the saturating sent-word counter.
    localparam int WORDS_SENT_W = 16;

endpackage : seq_pkg

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word input,
// one bit per clock out, with a one-entry holding register so consecutive
// words stream without a gap, a stall enable and a saturating word counter.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    en,
    output logic                    ser_out,
    output logic                    ser_valid,
    output logic                    ser_last,
    output logic                    busy,
    output logic [WORDS_SENT_W-1:0] words_sent
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                  state_reg, state_next;
    logic [WIDTH-1:0]        sr_reg, sr_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [WIDTH-1:0]        hold_reg, hold_next;
    logic                    hold_full_reg, hold_full_next;
    logic [WORDS_SENT_W-1:0] words_sent_reg, words_sent_next;

    logic [WIDTH-1:0]        sr_shifted;
    logic                    cur_bit;
    logic                    at_last;
    logic                    accept;
    logic                    bypass;

    // Shift register advanced one position toward the output end.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign sr_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign sr_shifted[gi] = sr_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign sr_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign sr_shifted[gi] = sr_reg[gi+1];
                end
            end
        end
    endgenerate

    assign cur_bit  = MSB_FIRST ? sr_reg[WIDTH-1] : sr_reg[0];
    assign at_last  = (cnt_reg == LAST_CNT);
    assign in_ready = !hold_full_reg;
    assign accept   = in_valid && in_ready;
    // A word arriving on the completing edge goes straight into sr when hold is empty.
    assign bypass   = (state_reg == SHIFT) && en && at_last && !hold_full_reg;

    assign ser_valid  = (state_reg == SHIFT) && en;
    assign ser_out    = ser_valid ? cur_bit : IDLE_BIT;
    assign ser_last   = ser_valid && at_last;
    assign busy       = (state_reg == SHIFT) || hold_full_reg;
    assign words_sent = words_sent_reg;

    // State register; reset discards both the in-flight and the held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sr_reg         <= '0;
            cnt_reg        <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            words_sent_reg <= '0;
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            cnt_reg        <= cnt_next;
            hold_reg       <= hold_next;
            hold_full_reg  <= hold_full_next;
            words_sent_reg <= words_sent_next;
        end
    end

    // Next-state logic: load, shift, word completion with source selection, hold fill.
    always_comb begin
        state_next      = state_reg;
        sr_next         = sr_reg;
        cnt_next        = cnt_reg;
        hold_next       = hold_reg;
        hold_full_next  = hold_full_reg;
        words_sent_next = words_sent_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    sr_next    = in_data;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (!at_last) begin
                        sr_next  = sr_shifted;
                        cnt_next = cnt_reg + CNT_W'(1);
                    end else begin
                        if (words_sent_reg != '1) begin
                            words_sent_next = words_sent_reg + WORDS_SENT_W'(1);
                        end
                        cnt_next = '0;
                        if (hold_full_reg) begin
                            sr_next        = hold_reg;
                            hold_full_next = 1'b0;
                        end else if (accept) begin
                            sr_next = in_data;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                // Any accepted word not taken by the bypass path waits in hold.
                if (accept && !bypass) begin
                    hold_next      = in_data;
                    hold_full_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule : seq_serializer
